// File: rtl/mips_pkg.sv
// Shared MIPS-lite definitions: opcode map, instruction classes, retire FSM
// states and the opcode classifier used by the retire statistics monitor.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned DRAIN_W  = 4;

    typedef enum logic [OPCODE_W-1:0] {
        ADD  = 6'h00,
        ADDI = 6'h01,
        SUB  = 6'h02,
        SUBI = 6'h03,
        MUL  = 6'h04,
        MULI = 6'h05,
        OR   = 6'h06,
        ORI  = 6'h07,
        AND  = 6'h08,
        ANDI = 6'h09,
        XOR  = 6'h0A,
        XORI = 6'h0B,
        LDW  = 6'h0C,
        STW  = 6'h0D,
        BZ   = 6'h0E,
        BEQ  = 6'h0F,
        JR   = 6'h10,
        HALT = 6'h11
    } opcode_e;

    typedef enum logic [2:0] {
        ARITH,
        LOGIC,
        MEM,
        CTRL,
        ILLEGAL
    } instr_class_e;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } retire_state_e;

    // Opcodes 0x12-0x3F have no decode and fall into ILLEGAL.
    function automatic instr_class_e class_of(input logic [OPCODE_W-1:0] opcode);
        instr_class_e cls;
        case (opcode)
            ADD, ADDI, SUB, SUBI, MUL, MULI: cls = ARITH;
            OR, ORI, AND, ANDI, XOR, XORI:   cls = LOGIC;
            LDW, STW:                        cls = MEM;
            BZ, BEQ, JR, HALT:               cls = CTRL;
            default:                         cls = ILLEGAL;
        endcase
        return cls;
    endfunction

    // Control transfers that can redirect the PC (HALT never does).
    function automatic logic is_redirect(input logic [OPCODE_W-1:0] opcode);
        return (opcode == BZ) || (opcode == BEQ) || (opcode == JR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous reset and clear.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/retire_stats_monitor.sv
// Classifies retired instructions into saturating statistics counters and
// freezes them a fixed number of cycles after HALT retires.
module retire_stats_monitor
    import mips_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 retire_valid,
    input  logic [5:0]           retire_opcode,
    input  logic                 retire_taken,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] arith_count,
    output logic [CNT_WIDTH-1:0] logic_count,
    output logic [CNT_WIDTH-1:0] mem_count,
    output logic [CNT_WIDTH-1:0] ctrl_count,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic [CNT_WIDTH-1:0] illegal_count,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 halted,
    output logic                 done
);

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    retire_state_e      state_q;
    retire_state_e      state_d;
    logic [DRAIN_W-1:0] drain_q;
    logic [DRAIN_W-1:0] drain_d;
    logic               halted_q;
    logic               halted_d;
    logic               done_q;
    logic               done_d;

    instr_class_e       cls_c;
    logic               run_c;
    logic               retire_c;
    logic               halt_c;

    logic inc_instr_c;
    logic inc_arith_c;
    logic inc_logic_c;
    logic inc_mem_c;
    logic inc_ctrl_c;
    logic inc_taken_c;
    logic inc_illegal_c;

    // Counting only happens in RUN; a clear cycle drops whatever retires in it.
    assign cls_c    = class_of(retire_opcode);
    assign run_c    = (state_q == RUN) && !clear;
    assign retire_c = run_c && retire_valid;
    assign halt_c   = retire_c && (retire_opcode == HALT);

    assign inc_instr_c   = retire_c && (cls_c != ILLEGAL);
    assign inc_arith_c   = retire_c && (cls_c == ARITH);
    assign inc_logic_c   = retire_c && (cls_c == LOGIC);
    assign inc_mem_c     = retire_c && (cls_c == MEM);
    assign inc_ctrl_c    = retire_c && (cls_c == CTRL);
    assign inc_illegal_c = retire_c && (cls_c == ILLEGAL);
    assign inc_taken_c   = retire_c && is_redirect(retire_opcode) && retire_taken;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
            done_q   <= done_d;
        end
    end

    // Next state; the drain counter's last cycle is the one where it reads 1.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (clear) begin
            state_d = RUN;
            drain_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_c) begin
                        if (DRAIN_CYCLES != 0) begin
                            state_d = DRAIN;
                            drain_d = DRAIN_LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_d = DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they register with it.
    always_comb begin
        halted_d = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            DRAIN: halted_d = 1'b1;
            DONE: begin
                halted_d = 1'b1;
                done_d   = 1'b1;
            end
            default: begin
                halted_d = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    assign halted = halted_q;
    assign done   = done_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_instr_c), .count(instr_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_arith_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_arith_c), .count(arith_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_logic_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_logic_c), .count(logic_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_mem_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_mem_c), .count(mem_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_ctrl_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_ctrl_c), .count(ctrl_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_taken_c), .count(taken_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_illegal_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_illegal_c), .count(illegal_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk(clk), .reset(reset), .clear(clear), .inc(run_c), .count(cycle_count)
    );

endmodule

// File: tb/tb_retire_stats_monitor.sv
// Directed scoreboard bench for retire_stats_monitor: three configurations
// (default, 4-bit counters, zero drain) driven by one shared stimulus stream.
module tb_retire_stats_monitor;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ORI  = 6'h07;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;
    localparam logic [5:0] OP_I12  = 6'h12;
    localparam logic [5:0] OP_I3F  = 6'h3F;

    localparam int DUT_A  = 0;
    localparam int DUT_W4 = 1;
    localparam int DUT_D0 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       retire_valid;
    logic [5:0] retire_opcode;
    logic       retire_taken;

    logic [31:0] a_instr, a_arith, a_logic, a_mem, a_ctrl, a_taken, a_illegal, a_cycle;
    logic        a_halted, a_done;
    logic [3:0]  w_instr, w_arith, w_logic, w_mem, w_ctrl, w_taken, w_illegal, w_cycle;
    logic        w_halted, w_done;
    logic [31:0] z_instr, z_arith, z_logic, z_mem, z_ctrl, z_taken, z_illegal, z_cycle;
    logic        z_halted, z_done;

    typedef struct {
        int          tag;
        int          sel;
        logic [31:0] instr, arith, lgc, mem, ctrl, taken, illegal, cycle;
        logic        halted, done;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    next_tag = 0;

    always #5 clk = ~clk;

    retire_stats_monitor #(.CNT_WIDTH(32), .DRAIN_CYCLES(4)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear), .retire_valid(retire_valid),
        .retire_opcode(retire_opcode), .retire_taken(retire_taken),
        .instr_count(a_instr), .arith_count(a_arith), .logic_count(a_logic),
        .mem_count(a_mem), .ctrl_count(a_ctrl), .taken_count(a_taken),
        .illegal_count(a_illegal), .cycle_count(a_cycle), .halted(a_halted), .done(a_done)
    );

    retire_stats_monitor #(.CNT_WIDTH(4), .DRAIN_CYCLES(4)) u_dut_w4 (
        .clk(clk), .reset(reset), .clear(clear), .retire_valid(retire_valid),
        .retire_opcode(retire_opcode), .retire_taken(retire_taken),
        .instr_count(w_instr), .arith_count(w_arith), .logic_count(w_logic),
        .mem_count(w_mem), .ctrl_count(w_ctrl), .taken_count(w_taken),
        .illegal_count(w_illegal), .cycle_count(w_cycle), .halted(w_halted), .done(w_done)
    );

    retire_stats_monitor #(.CNT_WIDTH(32), .DRAIN_CYCLES(0)) u_dut_d0 (
        .clk(clk), .reset(reset), .clear(clear), .retire_valid(retire_valid),
        .retire_opcode(retire_opcode), .retire_taken(retire_taken),
        .instr_count(z_instr), .arith_count(z_arith), .logic_count(z_logic),
        .mem_count(z_mem), .ctrl_count(z_ctrl), .taken_count(z_taken),
        .illegal_count(z_illegal), .cycle_count(z_cycle), .halted(z_halted), .done(z_done)
    );

    function automatic snap_t observe(input int sel);
        snap_t s;
        s.tag = 0;
        s.sel = sel;
        case (sel)
            DUT_W4: begin
                s.instr = 32'(w_instr);   s.arith = 32'(w_arith);
                s.lgc   = 32'(w_logic);   s.mem   = 32'(w_mem);
                s.ctrl  = 32'(w_ctrl);    s.taken = 32'(w_taken);
                s.illegal = 32'(w_illegal); s.cycle = 32'(w_cycle);
                s.halted = w_halted;      s.done  = w_done;
            end
            DUT_D0: begin
                s.instr = z_instr;  s.arith = z_arith;  s.lgc = z_logic;  s.mem = z_mem;
                s.ctrl  = z_ctrl;   s.taken = z_taken;  s.illegal = z_illegal;
                s.cycle = z_cycle;  s.halted = z_halted; s.done = z_done;
            end
            default: begin
                s.instr = a_instr;  s.arith = a_arith;  s.lgc = a_logic;  s.mem = a_mem;
                s.ctrl  = a_ctrl;   s.taken = a_taken;  s.illegal = a_illegal;
                s.cycle = a_cycle;  s.halted = a_halted; s.done = a_done;
            end
        endcase
        return s;
    endfunction

    task automatic chk(input int tag, input int sel, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL chk%0d dut%0d %s: got %0d, required %0d", tag, sel, nm, act, req);
        end
    endtask

    // Scoreboard push: expected outputs of DUT `sel` after the edge just taken.
    task automatic expect_state(input int sel,
                                input int unsigned e_instr, e_arith, e_logic, e_mem,
                                input int unsigned e_ctrl, e_taken, e_illegal, e_cycle,
                                input logic e_halted, e_done);
        snap_t s;
        s.tag = next_tag;
        s.sel = sel;
        s.instr = 32'(e_instr);   s.arith = 32'(e_arith);
        s.lgc   = 32'(e_logic);   s.mem   = 32'(e_mem);
        s.ctrl  = 32'(e_ctrl);    s.taken = 32'(e_taken);
        s.illegal = 32'(e_illegal); s.cycle = 32'(e_cycle);
        s.halted = e_halted;      s.done  = e_done;
        exp_q.push_back(s);
        next_tag++;
    endtask

    task automatic expect_zero(input int sel);
        expect_state(sel, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t a;
            e = exp_q.pop_front();
            a = observe(e.sel);
            chk(e.tag, e.sel, "instr",   a.instr,   e.instr);
            chk(e.tag, e.sel, "arith",   a.arith,   e.arith);
            chk(e.tag, e.sel, "logic",   a.lgc,     e.lgc);
            chk(e.tag, e.sel, "mem",     a.mem,     e.mem);
            chk(e.tag, e.sel, "ctrl",    a.ctrl,    e.ctrl);
            chk(e.tag, e.sel, "taken",   a.taken,   e.taken);
            chk(e.tag, e.sel, "illegal", a.illegal, e.illegal);
            chk(e.tag, e.sel, "cycle",   a.cycle,   e.cycle);
            chk(e.tag, e.sel, "halted",  32'(a.halted), 32'(e.halted));
            chk(e.tag, e.sel, "done",    32'(a.done),   32'(e.done));
        end
    end

    task automatic step(input logic v, input logic [5:0] op, input logic tk,
                        input logic clr, input logic rst);
        retire_valid  = v;
        retire_opcode = op;
        retire_taken  = tk;
        clear         = clr;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [5:0] op, input logic tk);
        step(1'b1, op, tk, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; retire_valid = 1'b0;
        retire_opcode = '0; retire_taken = 1'b0;

        // Reset state of all three configurations.
        step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
        step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
        expect_zero(DUT_A);
        expect_zero(DUT_W4);
        expect_zero(DUT_D0);

        // Mixed program; taken on ADD must be ignored.
        retire(OP_ADD, 1'b1);
        expect_state(DUT_A, 1, 1, 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);
        retire(OP_ORI, 1'b0);
        retire(OP_LDW, 1'b0);
        retire(OP_STW, 1'b0);
        retire(OP_BEQ, 1'b1);
        expect_state(DUT_A,  5, 1, 1, 2, 1, 1, 0, 5, 1'b0, 1'b0);
        expect_state(DUT_D0, 5, 1, 1, 2, 1, 1, 0, 5, 1'b0, 1'b0);
        retire(OP_HALT, 1'b0);
        expect_state(DUT_A,  6, 1, 1, 2, 2, 1, 0, 6, 1'b1, 1'b0);
        expect_state(DUT_D0, 6, 1, 1, 2, 2, 1, 0, 6, 1'b1, 1'b1);

        // Retirements during the four DRAIN cycles are ignored; done rises on the 4th.
        for (int i = 0; i < 3; i++) begin
            retire(OP_ADD, 1'b0);
            expect_state(DUT_A, 6, 1, 1, 2, 2, 1, 0, 6, 1'b1, 1'b0);
        end
        retire(OP_ADD, 1'b0);
        expect_state(DUT_A,  6, 1, 1, 2, 2, 1, 0, 6, 1'b1, 1'b1);
        expect_state(DUT_D0, 6, 1, 1, 2, 2, 1, 0, 6, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            retire(OP_ADD, 1'b1);
            expect_state(DUT_A, 6, 1, 1, 2, 2, 1, 0, 6, 1'b1, 1'b1);
        end

        // Clear from DONE returns to RUN with zeroed counters.
        step(1'b1, OP_ADD, 1'b0, 1'b1, 1'b0);
        expect_zero(DUT_A);
        retire(OP_ADD, 1'b0);
        expect_state(DUT_A, 1, 1, 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);

        // Illegal opcodes, then HALT, then clear in the 2nd DRAIN cycle.
        step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
        retire(OP_I3F, 1'b0);
        retire(OP_I3F, 1'b1);
        retire(OP_I3F, 1'b0);
        retire(OP_HALT, 1'b0);
        expect_state(DUT_A, 1, 0, 0, 0, 1, 0, 3, 4, 1'b1, 1'b0);
        retire(OP_ADD, 1'b0);
        expect_state(DUT_A, 1, 0, 0, 0, 1, 0, 3, 4, 1'b1, 1'b0);
        step(1'b1, OP_ADD, 1'b0, 1'b1, 1'b0);
        expect_zero(DUT_A);
        retire(OP_ADD, 1'b0);
        expect_state(DUT_A, 1, 1, 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);

        // 4-bit counters saturate at 15.
        step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            retire(OP_ADD, 1'b0);
            if (i == 13) expect_state(DUT_W4, 14, 14, 0, 0, 0, 0, 0, 14, 1'b0, 1'b0);
            if (i == 14) expect_state(DUT_W4, 15, 15, 0, 0, 0, 0, 0, 15, 1'b0, 1'b0);
        end
        expect_state(DUT_W4, 15, 15, 0, 0, 0, 0, 0, 15, 1'b0, 1'b0);

        // Reset wins over a concurrent retirement.
        step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1);
        step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1);
        expect_zero(DUT_D0);
        expect_zero(DUT_A);

        // Zero-drain config: first illegal opcode, branches, HALT goes straight to DONE.
        retire(OP_I12, 1'b1);
        expect_state(DUT_D0, 0, 0, 0, 0, 0, 0, 1, 1, 1'b0, 1'b0);
        retire(OP_BZ, 1'b1);
        expect_state(DUT_D0, 1, 0, 0, 0, 1, 1, 1, 2, 1'b0, 1'b0);
        retire(OP_JR, 1'b0);
        expect_state(DUT_D0, 2, 0, 0, 0, 2, 1, 1, 3, 1'b0, 1'b0);
        retire(OP_HALT, 1'b1);
        expect_state(DUT_D0, 3, 0, 0, 0, 3, 1, 1, 4, 1'b1, 1'b1);
        step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1);
        expect_zero(DUT_D0);
        step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/retire_stats_monitor.md
# retire_stats_monitor

Downstream consumer of the writeback stage in the MIPS-lite pipeline. It observes one retired instruction per cycle and classifies it by opcode into arithmetic, logical, memory or control-transfer. It keeps saturating per-class, taken-branch and cycle counters, and runs a small state machine that detects HALT retirement, drains for a fixed number of cycles, then freezes all counts and raises `done` for the end-of-simulation report.

## Interface
Parameters:
- `CNT_WIDTH`, default 32: width of every counter output.
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN after HALT retires. Legal range 0–15.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `clear`, input, 1: synchronous counter clear. Lower priority than `reset`.
- `retire_valid`, input, 1: an instruction retires this cycle.
- `retire_opcode`, input, 6: opcode of the retiring instruction, `Instruct` opcode field.
- `retire_taken`, input, 1: the retiring BZ/BEQ/JR redirected the PC. Ignored for other opcodes.
- `instr_count`, output, `CNT_WIDTH`: legal instructions retired.
- `arith_count`, output, `CNT_WIDTH`: ADD, ADDI, SUB, SUBI, MUL, MULI.
- `logic_count`, output, `CNT_WIDTH`: OR, ORI, AND, ANDI, XOR, XORI.
- `mem_count`, output, `CNT_WIDTH`: LDW, STW.
- `ctrl_count`, output, `CNT_WIDTH`: BZ, BEQ, JR, HALT.
- `taken_count`, output, `CNT_WIDTH`: control transfers with `retire_taken`=1.
- `illegal_count`, output, `CNT_WIDTH`: opcodes 0x12–0x3F.
- `cycle_count`, output, `CNT_WIDTH`: cycles spent in RUN, including the HALT-retire cycle.
- `halted`, output, 1: high in DRAIN and DONE.
- `done`, output, 1: high in DONE only.

## Operation
- Opcode map (`mips_pkg`): ADD 0x00, ADDI 0x01, SUB 0x02, SUBI 0x03, MUL 0x04, MULI 0x05, OR 0x06, ORI 0x07, AND 0x08, ANDI 0x09, XOR 0x0A, XORI 0x0B, LDW 0x0C, STW 0x0D, BZ 0x0E, BEQ 0x0F, JR 0x10, HALT 0x11.
- States: RUN, DRAIN, DONE. Reset state is RUN.
- RUN:
  - `cycle_count` increments every cycle.
  - On `retire_valid`, the matching class counter increments.
  - For a legal opcode, `instr_count` also increments. An illegal opcode increments only `illegal_count`.
  - `taken_count` increments when `retire_valid`, the opcode is BZ/BEQ/JR, and `retire_taken`=1.
- Leaving RUN on HALT retirement (HALT itself counted in `ctrl_count` and `instr_count`):
  - To DRAIN if `DRAIN_CYCLES`>0.
  - Otherwise straight to DONE.
- DRAIN: an internal 4-bit down-counter loads `DRAIN_CYCLES`. The block moves to DONE when it expires, after exactly `DRAIN_CYCLES` cycles in DRAIN. Retirements in DRAIN/DONE are ignored and no counter changes.
- DONE: all outputs hold until `reset` or `clear`.
- Every counter saturates at all-ones and never wraps.
- `clear`: all counters go to 0 and the state returns to RUN. The clear cycle is not counted, and any retirement in that cycle is dropped.
- Reset values: all counters 0, `halted`=0, `done`=0, state RUN, drain counter 0.
- Priority: `reset` > `clear` > retirement/FSM update.

## Timing
- Single-cycle latency: an event sampled at edge N is visible on the outputs after edge N.
- HALT retires at edge N:
  - `halted`=1 after edge N.
  - `done`=1 after edge N+`DRAIN_CYCLES`, or after edge N when `DRAIN_CYCLES`=0.
- `cycle_count` after HALT at edge N from reset release at edge 0 equals N+1.
- No backpressure; `retire_valid` is accepted every cycle in RUN.
- `reset` or `clear` in DRAIN aborts the drain; the next cycle is RUN with zeroed counters.

## Structure
- `mips_pkg` holds:
  - The `opcode_e` enum with the values above.
  - The `instr_class_e` enum {ARITH, LOGIC, MEM, CTRL, ILLEGAL}.
  - The `retire_state_e` enum {RUN, DRAIN, DONE}.
  - The `class_of(opcode)` function.
- Sub-module `sat_counter` (parameter `WIDTH`; ports `clk`, `reset`, `clear`, `inc`, `count`) is instantiated once per counter. It saturates at all-ones.

## Test plan
- Reset, then retire ADD, ORI, LDW, STW, BEQ(taken), HALT on consecutive cycles. Required with `DRAIN_CYCLES`=4:
  - instr=6, arith=1, logic=1, mem=2, ctrl=2, taken=1.
  - `halted` is high on the cycle after HALT; `done` is high exactly 4 cycles after `halted` rises.
- Retire opcode 0x3F three times, then HALT. Required: illegal=3, instr=1, ctrl=1.
- Retire ADD in each of the 4 DRAIN cycles and while in DONE. Required: all counters unchanged from their HALT-cycle values, `cycle_count` frozen.
- With `CNT_WIDTH`=4, retire 20 ADDs. Required: arith=15, instr=15, no wrap.
- Assert `clear` in the 2nd DRAIN cycle together with `retire_valid`. Required: next cycle all counters 0, `halted`=0, state RUN, and a following ADD gives arith=1.
- `DRAIN_CYCLES`=0: HALT retires at edge N. Required: `halted` and `done` both 1 after edge N. Assert `reset` together with `retire_valid`: counters stay 0.
